// File: rtl/mem_arb_pkg.sv
// Shared types and grant encodings for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Access timeout counter: cleared on grant, counts ACCESS cycles without
// mem_ready, flags expiry combinationally in the cycle the count would reach TIMEOUT_CYC.
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Expiry fires during the TIMEOUT_CYC-th idle ACCESS cycle, so ACCESS lasts exactly TIMEOUT_CYC cycles.
    assign o_expired = i_enable && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between the fetch and data ports, one access at a time,
// round-robin on ties. Define MEM_ARB_TIMEOUT_EN to build the ACCESS-state timeout/abort path.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              err
);

    state_t            r_state;
    state_t            w_next;
    logic              r_last;
    logic              r_port;
    logic              r_we;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              w_grant;
    logic              w_gnt_port;
    logic              w_expired;

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (reset),
        .i_clear  (w_grant),
        .i_enable ((r_state == ACCESS) && !mem_ready),
        .o_expired(w_expired)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC != 0);
    assign w_expired        = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_next     = r_state;
        w_grant    = 1'b0;
        w_gnt_port = GNT_IF;
        case (r_state)
            IDLE: begin
                if (if_req && dm_req) begin
                    w_grant    = 1'b1;
                    w_gnt_port = ~r_last;
                end else if (dm_req) begin
                    w_grant    = 1'b1;
                    w_gnt_port = GNT_DM;
                end else if (if_req) begin
                    w_grant    = 1'b1;
                    w_gnt_port = GNT_IF;
                end
                if (w_grant) w_next = ACCESS;
            end
            ACCESS:  if (mem_ready || w_expired) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_last     <= GNT_IF;
            r_port     <= GNT_IF;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_port  <= w_gnt_port;
                r_last  <= w_gnt_port;
                r_addr  <= (w_gnt_port == GNT_DM) ? dm_addr : if_addr;
                r_we    <= (w_gnt_port == GNT_DM) ? dm_we : 1'b0;
                r_wdata <= (w_gnt_port == GNT_DM) ? dm_wdata : '0;
            end
            if (r_state == ACCESS) begin
                r_err <= ~mem_ready & w_expired;
                if (mem_ready) begin
                    if (!r_we) begin
                        if (r_port == GNT_DM) r_dm_rdata <= mem_rdata;
                        else                  r_if_rdata <= mem_rdata;
                    end
                end else if (w_expired) begin
                    if (r_port == GNT_DM) r_dm_rdata <= '0;
                    else                  r_if_rdata <= '0;
                end
            end
        end
    end

    // mem_cs decodes the state register, so an asynchronous reset drops it at once.
    assign mem_cs    = (r_state == ACCESS);
    assign mem_we    = mem_cs & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_done   = (r_state == RESP) && (r_port == GNT_IF);
    assign dm_done   = (r_state == RESP) && (r_port == GNT_DM);
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign busy      = (r_state != IDLE);
    assign err       = (r_state == RESP) & r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with an expected-completion scoreboard.
// Timeout cases run only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int TO = 4;

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        mem_cs;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        busy;
    logic        err;

    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_dm_rdata = '0;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_done  (dm_done),
        .mem_cs   (mem_cs),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pop the oldest expected completion and compare it with the done pulse seen now.
    task automatic pop_check();
        exp_t e;
        check("sb_not_empty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("if_done", if_done, e.port == GNT_IF);
            check("dm_done", dm_done, e.port == GNT_DM);
            check("err", err, e.err);
            check("mem_cs_resp", mem_cs, 0);
            if (e.port == GNT_DM) m_dm_rdata = e.rdata;
            else                  m_if_rdata = e.rdata;
            check("if_rdata", if_rdata, m_if_rdata);
            check("dm_rdata", dm_rdata, m_dm_rdata);
        end
    endtask

    // One complete transaction starting in an IDLE cycle; 'both' raises the other port too,
    // 'tmo' withholds mem_ready so the access must abort.
    task automatic access(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rd,
                          input int waits, input bit both, input bit tmo);
        exp_t        e;
        int          n;
        logic        exp_we;
        logic [31:0] exp_wd;
        exp_we = (port == GNT_DM) && we;
        exp_wd = (port == GNT_DM) ? wdata : 32'h0;
        if (port == GNT_DM) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
            if (both) begin if_req = 1'b1; if_addr = addr ^ 32'h100; end
        end else begin
            if_req = 1'b1; if_addr = addr;
            if (both) begin dm_req = 1'b1; dm_we = 1'b0; dm_addr = addr ^ 32'h200; end
        end
        e.port  = port;
        e.err   = tmo;
        e.rdata = tmo ? 32'h0 : (exp_we ? m_dm_rdata : rd);
        sb.push_back(e);
        n = tmo ? TO : waits + 1;
        step();
        for (int i = 0; i < n; i++) begin
            check("mem_cs", mem_cs, 1);
            check("busy", busy, 1);
            check("mem_addr", mem_addr, addr);
            check("mem_we", mem_we, exp_we);
            check("mem_wdata", mem_wdata, exp_wd);
            check("done_early", 64'(if_done | dm_done), 0);
            if_addr   = $urandom;
            dm_addr   = $urandom;
            dm_wdata  = $urandom;
            dm_we     = ~dm_we;
            mem_ready = !tmo && (i == n - 1);
            mem_rdata = mem_ready ? rd : $urandom;
            step();
        end
        pop_check();
        if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
        mem_rdata = $urandom;
        step();
        check("done_drop", 64'(if_done | dm_done), 0);
        check("busy_idle", busy, 0);
        check("mem_cs_idle", mem_cs, 0);
    endtask

    initial begin
        repeat (3) step();
        check("rst_mem_cs", mem_cs, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_done", 64'(if_done | dm_done), 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        reset = 1'b1;
        step();
        check("idle_after_rst", busy, 0);

        // Two ties straight after reset: data first, then fetch.
        access(GNT_DM, 1'b0, 32'h0000_0080, 32'h0, 32'h1111_1111, 0, 1'b1, 1'b0);
        access(GNT_IF, 1'b0, 32'h0000_0084, 32'h0, 32'h2222_2222, 0, 1'b1, 1'b0);

        // Minimum-latency fetch.
        access(GNT_IF, 1'b0, 32'h0000_0010, 32'h0, 32'h2402_0005, 0, 1'b0, 1'b0);

        // Store with three wait states; dm_rdata must keep the earlier load.
        access(GNT_DM, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'hFFFF_0000, 3, 1'b0, 1'b0);

        // Load with one wait, then a fetch to confirm independent rdata registers.
        access(GNT_DM, 1'b0, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 1, 1'b0, 1'b0);
        access(GNT_IF, 1'b0, 32'h0000_0014, 32'h0, 32'h0123_4567, 2, 1'b0, 1'b0);

        // Reset in the middle of ACCESS.
        if_req = 1'b1; if_addr = 32'h0000_0018;
        step();
        check("pre_rst_mem_cs", mem_cs, 1);
        #2 reset = 1'b0;
        #1;
        check("async_mem_cs", mem_cs, 0);
        check("async_busy", busy, 0);
        if_req = 1'b0;
        m_if_rdata = 32'h0;
        m_dm_rdata = 32'h0;
        step();
        check("rst_no_done", 64'(if_done | dm_done), 0);
        check("rst_clears_rdata", if_rdata, 0);
        #2 reset = 1'b1;
        step();
        check("rst_no_done_after", 64'(if_done | dm_done), 0);
        access(GNT_IF, 1'b0, 32'h0000_001C, 32'h0, 32'h89AB_CDEF, 0, 1'b0, 1'b0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Timeout abort forces rdata to 0; ready on the last allowed cycle still wins.
        access(GNT_IF, 1'b0, 32'h0000_0100, 32'h0, 32'h5555_5555, 0, 1'b0, 1'b1);
        access(GNT_IF, 1'b0, 32'h0000_0104, 32'h0, 32'h7777_7777, TO - 1, 1'b0, 1'b0);
        access(GNT_DM, 1'b0, 32'h0000_0108, 32'h0, 32'h9999_9999, 0, 1'b0, 1'b1);
`endif

        check("sb_drained", 64'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Hard bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
